// File: rtl/fifo_bist_pkg.sv
// Shared types and helpers for the FIFO BIST read-side checker.
// Optional MISR signature support is enabled with FIFO_CHK_MISR_EN.
package fifo_bist_pkg;

    localparam int DATA_WIDTH_DEF    = 10;
    localparam int DEPTH_DEF         = 10;
    localparam int ERR_CNT_WIDTH_DEF = 4;
    localparam int TIMEOUT_DEF       = 64;

    typedef enum logic [1:0] {
        CHK_IDLE,
        CHK_READ,
        CHK_DRAIN,
        CHK_DONE
    } chk_state_t;

    // Expected word for a given index. The caller truncates the result to its
    // data width, which gives the modulo-2^DATA_WIDTH wrap.
    function automatic logic [31:0] exp_word(input logic [31:0] seed, input logic [31:0] idx);
        return seed + idx;
    endfunction

endpackage

// File: rtl/fifo_chk_misr.sv
// Multiple-input signature register folding each valid read word.
// Used only when FIFO_CHK_MISR_EN is defined. Requires DATA_WIDTH >= 2.
module fifo_chk_misr #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] sig
);

    // Shift with a two-tap feedback, then XOR in the incoming word.
    always_ff @(posedge clk) begin
        if (!rst_n)   sig <= '0;
        else if (clr) sig <= '0;
        else if (en)  sig <= {sig[DATA_WIDTH-2:0], sig[DATA_WIDTH-1] ^ sig[DATA_WIDTH-2]} ^ din;
    end

endmodule

// File: rtl/fifo_read_checker.sv
// Read-side BIST checker: drains DEPTH words from the FIFO, compares them
// against an internally regenerated counting pattern and reports DONE/PASS.
// Define FIFO_CHK_MISR_EN to add the SIGNATURE port and MISR.
module fifo_read_checker
    import fifo_bist_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int SEED          = 0,
    parameter int ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF,
    localparam int IDX_W        = $clog2(DEPTH + 1),
    localparam int STALL_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic                     EMPTY,
    input  logic [DATA_WIDTH-1:0]    R_DATA,
    output logic                     R_EN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     PASS,
    output logic                     TIMED_OUT,
    output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
    output logic [IDX_W-1:0]         FAIL_IDX
`ifdef FIFO_CHK_MISR_EN
    ,
    output logic [DATA_WIDTH-1:0]    SIGNATURE
`endif
);

    chk_state_t state, state_nxt;

    logic [IDX_W-1:0]      issued;
    logic [IDX_W-1:0]      rd_idx;
    logic [STALL_W-1:0]    stall;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] exp_q;

    logic start_ok;
    logic last_issue;
    logic stall_out;
    logic mismatch;

    assign start_ok   = START && ((state == CHK_IDLE) || (state == CHK_DONE));
    assign R_EN       = (state == CHK_READ) && !EMPTY && (issued < IDX_W'(DEPTH));
    assign BUSY       = (state == CHK_READ) || (state == CHK_DRAIN);
    assign last_issue = R_EN && (issued == IDX_W'(DEPTH - 1));
    // Timeout is taken on an EMPTY cycle, so it can never coincide with a read.
    assign stall_out  = (state == CHK_READ) && EMPTY && (stall == STALL_W'(TIMEOUT - 1));
    assign mismatch   = rd_vld && (R_DATA != exp_q);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) state <= CHK_IDLE;
        else      state <= state_nxt;
    end

    // Next state: the last issue moves straight to DRAIN, whose single cycle
    // hosts the final compare.
    always_comb begin
        state_nxt = state;
        case (state)
            CHK_IDLE:  if (START) state_nxt = CHK_READ;
            CHK_READ:  if (last_issue || stall_out) state_nxt = CHK_DRAIN;
            CHK_DRAIN: state_nxt = CHK_DONE;
            CHK_DONE:  if (START) state_nxt = CHK_READ;
            default:   state_nxt = CHK_IDLE;
        endcase
    end

    // Issue/stall counters and the one-deep compare pipeline.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            issued <= '0;
            stall  <= '0;
            rd_vld <= 1'b0;
            rd_idx <= '0;
            exp_q  <= '0;
        end else begin
            if (start_ok) begin
                issued <= '0;
                stall  <= '0;
            end else if (R_EN) begin
                issued <= issued + 1'b1;
                stall  <= '0;
            end else if ((state == CHK_READ) && EMPTY) begin
                stall  <= stall + 1'b1;
            end
            rd_vld <= R_EN;
            if (R_EN) begin
                rd_idx <= issued;
                exp_q  <= DATA_WIDTH'(exp_word(SEED, 32'(issued)));
            end
        end
    end

    // Result registers: error count, first failing index, timeout and verdict.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ERR_CNT   <= '0;
            FAIL_IDX  <= IDX_W'(DEPTH);
            TIMED_OUT <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else if (start_ok) begin
            ERR_CNT   <= '0;
            FAIL_IDX  <= IDX_W'(DEPTH);
            TIMED_OUT <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            if (mismatch) begin
                if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
                if (ERR_CNT == '0) FAIL_IDX <= rd_idx;
            end
            if (stall_out) TIMED_OUT <= 1'b1;
            if (state == CHK_DRAIN) begin
                DONE <= 1'b1;
                PASS <= (ERR_CNT == '0) && !mismatch && !TIMED_OUT;
            end
        end
    end

`ifdef FIFO_CHK_MISR_EN
    // rd_vld is never set in DONE, so the signature holds until the next START.
    fifo_chk_misr #(.DATA_WIDTH(DATA_WIDTH)) u_misr (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (start_ok),
        .en    (rd_vld),
        .din   (R_DATA),
        .sig   (SIGNATURE)
    );
`endif

endmodule

// File: tb/tb_fifo_read_checker.sv
// Directed bench for fifo_read_checker with a small behavioural FIFO model.
// With FIFO_CHK_MISR_EN defined it also checks the MISR signature.
module tb_fifo_read_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       empty;
    logic [9:0] r_data = '0;
    logic       r_en, busy, done, pass, timed_out;
    logic [3:0] err_cnt;
    logic [3:0] fail_idx;
`ifdef FIFO_CHK_MISR_EN
    logic [9:0] signature;
`endif

    always #5 clk = ~clk;

    fifo_read_checker #(
        .DATA_WIDTH(10), .DEPTH(10), .SEED(0), .ERR_CNT_WIDTH(4), .TIMEOUT(64)
    ) dut (
        .CLK(clk), .RST(rst), .START(start), .EMPTY(empty), .R_DATA(r_data),
        .R_EN(r_en), .BUSY(busy), .DONE(done), .PASS(pass), .TIMED_OUT(timed_out),
        .ERR_CNT(err_cnt), .FAIL_IDX(fail_idx)
`ifdef FIFO_CHK_MISR_EN
        , .SIGNATURE(signature)
`endif
    );

    // FIFO model: mem/wr_cnt loaded by the stimulus, read pointer advanced on R_EN.
    logic [9:0] mem [0:15];
    int         wr_cnt = 0;
    int         rd_ptr = 0;
    logic       tb_clr = 1'b0;
    logic       toggle_en = 1'b0;
    logic       force_empty = 1'b0;
    int         cyc = 0;
    int         ren_cnt = 0;
    int         first_ren = 0;
    int         last_ren = 0;
    int         bad_ren = 0;
    int         done_cyc = 0;
    int         checks = 0;
    int         failures = 0;

    assign empty = (rd_ptr >= wr_cnt) || force_empty;

    // Read port, cycle counter and R_EN monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tb_clr) begin
            rd_ptr  <= 0;
            ren_cnt <= 0;
            bad_ren <= 0;
        end else if (r_en) begin
            r_data  <= mem[rd_ptr[3:0]];
            rd_ptr  <= rd_ptr + 1;
            ren_cnt <= ren_cnt + 1;
            last_ren <= cyc;
            if (ren_cnt == 0) first_ren <= cyc;
            if (empty || !busy) bad_ren <= bad_ren + 1;
        end
    end

    // EMPTY toggling every cycle for the stall test.
    always @(negedge clk) begin
        if (toggle_en) force_empty <= ~force_empty;
        else           force_empty <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic prep(input int n);
        @(negedge clk);
        for (int i = 0; i < 16; i++) mem[i] = 10'(i);
        wr_cnt = n;
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

`ifdef FIFO_CHK_MISR_EN
    function automatic logic [9:0] golden_sig();
        logic [9:0] g = '0;
        for (int i = 0; i < 10; i++) g = {g[8:0], g[9] ^ g[8]} ^ 10'(i);
        return g;
    endfunction
`endif

    initial begin
        int ren_snap;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ren", 32'(r_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_tmo", 32'(timed_out), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_fidx", 32'(fail_idx), 32'd10);
        rst = 1'b1;

        // 1: clean run
        prep(10);
        start_run();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1");
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err", 32'(err_cnt), 32'd0);
        chk("t1_fidx", 32'(fail_idx), 32'd10);
        chk("t1_ren", 32'(ren_cnt), 32'd10);
        chk("t1_lat", 32'(done_cyc - last_ren), 32'd2);
        chk("t1_span", 32'(last_ren - first_ren), 32'd9);
        chk("t1_bad", 32'(bad_ren), 32'd0);
`ifdef FIFO_CHK_MISR_EN
        chk("t1_sig", 32'(signature), 32'(golden_sig()));
`endif

        // 2: word 4 corrupted
        prep(10);
        mem[4] = 10'h3FF;
        start_run();
        wait_done("t2");
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_err", 32'(err_cnt), 32'd1);
        chk("t2_fidx", 32'(fail_idx), 32'd4);
        chk("t2_ren", 32'(ren_cnt), 32'd10);

        // 2b: words 4 and 9 corrupted; last word compared, first index kept
        prep(10);
        mem[4] = 10'h3FF;
        mem[9] = 10'h000;
        start_run();
        wait_done("t2b");
        chk("t2b_err", 32'(err_cnt), 32'd2);
        chk("t2b_fidx", 32'(fail_idx), 32'd4);
        chk("t2b_pass", 32'(pass), 32'd0);

        // 3: EMPTY toggling every cycle
        prep(10);
        toggle_en = 1'b1;
        start_run();
        wait_done("t3");
        toggle_en = 1'b0;
        chk("t3_pass", 32'(pass), 32'd1);
        chk("t3_ren", 32'(ren_cnt), 32'd10);
        chk("t3_span", 32'(last_ren - first_ren), 32'd18);
        chk("t3_bad", 32'(bad_ren), 32'd0);

        // 4: only 6 words, timeout
        prep(6);
        start_run();
        wait_done("t4");
        chk("t4_tmo", 32'(timed_out), 32'd1);
        chk("t4_pass", 32'(pass), 32'd0);
        chk("t4_err", 32'(err_cnt), 32'd0);
        chk("t4_ren", 32'(ren_cnt), 32'd6);
        chk("t4_bad", 32'(bad_ren), 32'd0);

        // 5: reset in the cycle after the 5th R_EN
        prep(10);
        start_run();
        for (int i = 0; i < 50; i++) begin
            if (ren_cnt >= 5) break;
            @(negedge clk);
        end
        chk("t5_reach5", 32'(ren_cnt), 32'd5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t5_ren", 32'(r_en), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_pass", 32'(pass), 32'd0);
        chk("t5_err", 32'(err_cnt), 32'd0);
        chk("t5_fidx", 32'(fail_idx), 32'd10);
        ren_snap = ren_cnt;
        repeat (10) @(negedge clk);
        chk("t5_no_ren", 32'(ren_cnt), 32'(ren_snap));
        chk("t5_idle", 32'(busy), 32'd0);

        // 6: START while busy ignored, then restart from DONE clears results
        prep(10);
        mem[2] = 10'h3FF;
        start_run();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6a");
        chk("t6a_ren", 32'(ren_cnt), 32'd10);
        chk("t6a_err", 32'(err_cnt), 32'd1);
        chk("t6a_fidx", 32'(fail_idx), 32'd2);
        prep(10);
        start_run();
        chk("t6b_done", 32'(done), 32'd0);
        chk("t6b_err", 32'(err_cnt), 32'd0);
        chk("t6b_fidx", 32'(fail_idx), 32'd10);
        chk("t6b_busy", 32'(busy), 32'd1);
        wait_done("t6b");
        chk("t6b_pass", 32'(pass), 32'd1);
        chk("t6b_ren", 32'(ren_cnt), 32'd10);
`ifdef FIFO_CHK_MISR_EN
        chk("t6b_sig", 32'(signature), 32'(golden_sig()));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
